// File: rtl/queue_28x3_pkg.sv
// Shared constants, types and pointer-wrap helper for the 28x3 queue.
// Optional flow-through mode is selected by QUEUE_28X3_FLOW_EN (see queue_28x3.sv).
package queue_28x3_pkg;

  localparam int DEPTH = 28;
  localparam int WIDTH = 3;
  localparam int PTR_W = 5;
  localparam int CNT_W = 5;

  typedef logic [WIDTH-1:0] payload_t;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam ptr_t LAST_IDX = 5'd27;
  localparam cnt_t FULL_CNT = 5'd28;

  // Depth is not a power of two, so the wrap back to entry 0 is explicit.
  function automatic ptr_t next_ptr(input ptr_t p);
    return (p == LAST_IDX) ? '0 : p + 5'd1;
  endfunction

endpackage

// File: rtl/queue_28x3_ram.sv
// 28x3 register-file storage: synchronous write port W0, combinational read port R0.
// Contents are deliberately not reset.
module queue_28x3_ram
  import queue_28x3_pkg::*;
(
  input  logic [PTR_W-1:0] R0_addr,
  input  logic             R0_en,
  input  logic             R0_clk,
  output logic [WIDTH-1:0] R0_data,
  input  logic [PTR_W-1:0] W0_addr,
  input  logic             W0_en,
  input  logic             W0_clk,
  input  logic [WIDTH-1:0] W0_data
);

  payload_t mem_q [DEPTH];

  // The read is asynchronous; R0_clk exists only to keep the standard port set.
  logic r0_clk_unused;
  assign r0_clk_unused = R0_clk;

  always_ff @(posedge W0_clk) begin
    if (W0_en) begin
      mem_q[W0_addr] <= W0_data;
    end
  end

  always_comb begin
    R0_data = '0;
    if (R0_en && (R0_addr <= LAST_IDX)) begin
      R0_data = mem_q[R0_addr];
    end
  end

endmodule

// File: rtl/queue_28x3.sv
// 28-entry 3-bit ready/valid FIFO controller around queue_28x3_ram.
// Define QUEUE_28X3_FLOW_EN for zero-latency flow-through when the queue is empty.
module queue_28x3
  import queue_28x3_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             io_enq_valid,
  output logic             io_enq_ready,
  input  logic [WIDTH-1:0] io_enq_bits,
  output logic             io_deq_valid,
  input  logic             io_deq_ready,
  output logic [WIDTH-1:0] io_deq_bits,
  output logic [CNT_W-1:0] io_count
);

  ptr_t     enq_ptr_q, enq_ptr_d;
  ptr_t     deq_ptr_q, deq_ptr_d;
  cnt_t     count_q, count_d;
  logic     empty, full;
  logic     enq_fire, deq_fire;
  logic     do_enq, do_deq;
  payload_t ram_rdata;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; ready never looks at the partner's valid, and enq_ready is a pure function
  // of state, so a full queue refuses even when a dequeue fires in the same cycle.
  assign io_enq_ready = ~full;
  assign enq_fire     = io_enq_valid & io_enq_ready;
  assign deq_fire     = io_deq_valid & io_deq_ready;

`ifdef QUEUE_28X3_FLOW_EN
  logic bypass;
  assign io_deq_valid = empty ? io_enq_valid : 1'b1;
  assign io_deq_bits  = io_deq_valid ? (empty ? io_enq_bits : ram_rdata) : '0;
  // A payload consumed in the same cycle it arrives never touches the memory.
  assign bypass = empty & io_enq_valid & io_deq_ready;
  assign do_enq = enq_fire & ~bypass;
  assign do_deq = deq_fire & ~empty;
`else
  assign io_deq_valid = ~empty;
  assign io_deq_bits  = io_deq_valid ? ram_rdata : '0;
  assign do_enq = enq_fire;
  assign do_deq = deq_fire;
`endif

  assign io_count = count_q;

  always_comb begin
    enq_ptr_d = enq_ptr_q;
    deq_ptr_d = deq_ptr_q;
    count_d   = count_q;
    if (do_enq) begin
      enq_ptr_d = next_ptr(enq_ptr_q);
    end
    if (do_deq) begin
      deq_ptr_d = next_ptr(deq_ptr_q);
    end
    case ({do_enq, do_deq})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      enq_ptr_q <= '0;
      deq_ptr_q <= '0;
      count_q   <= '0;
    end else begin
      enq_ptr_q <= enq_ptr_d;
      deq_ptr_q <= deq_ptr_d;
      count_q   <= count_d;
    end
  end

  queue_28x3_ram u_ram (
    .R0_addr (deq_ptr_q),
    .R0_en   (~empty),
    .R0_clk  (clock),
    .R0_data (ram_rdata),
    .W0_addr (enq_ptr_q),
    .W0_en   (do_enq),
    .W0_clk  (clock),
    .W0_data (io_enq_bits)
  );

endmodule
